// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer: assembles header/payload/trailer byte frames from a UART
// byte stream and presents good frames on a valid/ready output register.
module uart_cmd_framer #(
  parameter int PAYLOAD_BYTES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [7:0]                 cmd,
  output logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       err_mismatch,
  output logic                       err_timeout,
  output logic                       err_overrun,
  output logic [7:0]                 frames_ok,
  output logic [7:0]                 frames_bad
);

  localparam int PW    = 8 * PAYLOAD_BYTES;
  localparam int CNT_W = $clog2(PAYLOAD_BYTES + 2);
  localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(PAYLOAD_BYTES + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, RECV} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       hdr_q, hdr_d;
  logic [PW-1:0]    shift_q, shift_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [PW-1:0]    pay_q, pay_d;
  logic             fv_q, fv_d;
  logic             mm_q, mm_d, to_q, to_d, ov_q, ov_d;
  logic [7:0]       ok_q, ok_d, bad_q, bad_d;
  logic             load;

  // Frame collection, evaluation, timeout and output handshake
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    hdr_d   = hdr_q;
    shift_d = shift_q;
    cmd_d   = cmd_q;
    pay_d   = pay_q;
    fv_d    = fv_q & ~frame_ready;
    mm_d    = 1'b0;
    to_d    = 1'b0;
    ov_d    = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        gap_d = '0;
        if (rx_valid) begin
          hdr_d   = rx_data;
          cnt_d   = CNT_W'(1);
          state_d = RECV;
        end
      end
      RECV: begin
        if (rx_valid) begin
          // A byte always beats an expiring gap counter
          gap_d = '0;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (rx_data != hdr_q) begin
              mm_d = 1'b1;
            end else if (!fv_q || frame_ready) begin
              cmd_d = hdr_q;
              pay_d = shift_q;
              fv_d  = 1'b1;
              load  = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end else begin
            shift_d = {shift_q[PW-9:0], rx_data};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (gap_q == GAP_MAX) begin
          to_d    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ok_d  = (load && ok_q != 8'hFF) ? ok_q + 8'd1 : ok_q;
    bad_d = ((mm_d | to_d | ov_d) && bad_q != 8'hFF) ? bad_q + 8'd1 : bad_q;
  end

  // State and output registers; reset drops any partial frame silently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      hdr_q   <= '0;
      shift_q <= '0;
      cmd_q   <= '0;
      pay_q   <= '0;
      fv_q    <= 1'b0;
      mm_q    <= 1'b0;
      to_q    <= 1'b0;
      ov_q    <= 1'b0;
      ok_q    <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      hdr_q   <= hdr_d;
      shift_q <= shift_d;
      cmd_q   <= cmd_d;
      pay_q   <= pay_d;
      fv_q    <= fv_d;
      mm_q    <= mm_d;
      to_q    <= to_d;
      ov_q    <= ov_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
    end
  end

  assign cmd          = cmd_q;
  assign payload      = pay_q;
  assign frame_valid  = fv_q;
  assign err_mismatch = mm_q;
  assign err_timeout  = to_q;
  assign err_overrun  = ov_q;
  assign frames_ok    = ok_q;
  assign frames_bad   = bad_q;

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer with a short timeout.
module tb_uart_cmd_framer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         frame_ready = 1'b0;
  logic [7:0]   cmd;
  logic [127:0] payload;
  logic         frame_valid, err_mismatch, err_timeout, err_overrun;
  logic [7:0]   frames_ok, frames_bad;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int n_mm = 0, n_to = 0, n_ov = 0;

  uart_cmd_framer #(.PAYLOAD_BYTES(16), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd(cmd), .payload(payload), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .err_mismatch(err_mismatch),
    .err_timeout(err_timeout), .err_overrun(err_overrun),
    .frames_ok(frames_ok), .frames_bad(frames_bad)
  );

  always #5 clk = ~clk;

  // Count error-pulse cycles away from the active edge
  always @(negedge clk) begin
    if (err_mismatch) n_mm++;
    if (err_timeout)  n_to++;
    if (err_overrun)  n_ov++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] base, input logic [7:0] step, input int first, input int n);
    for (int i = first; i < first + n; i++) send(base + 8'(i) * step);
  endtask

  function automatic logic [127:0] exp_pay(input logic [7:0] base, input logic [7:0] step);
    logic [127:0] p = '0;
    for (int i = 0; i < 16; i++) p = {p[119:0], base + 8'(i) * step};
    return p;
  endfunction

  task automatic send_frame(input logic [7:0] h, input logic [7:0] t,
                            input logic [7:0] base, input logic [7:0] step);
    send(h);
    send_payload(base, step, 0, 16);
    send(t);
  endtask

  task automatic consume();
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_cmd", cmd, 0);
    check("rst_payload", payload, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_errs", {err_mismatch, err_timeout, err_overrun}, 0);
    check("rst_ok", frames_ok, 0);
    check("rst_bad", frames_bad, 0);
    rst = 1'b1;
    idle(2);

    // Good frame "E", 00..0F, "E"
    send_frame(8'h45, 8'h45, 8'h00, 8'h01);
    check("good_fv", frame_valid, 1);
    check("good_cmd", cmd, 8'h45);
    check("good_payload", payload, 128'h000102030405060708090A0B0C0D0E0F);
    check("good_ok", frames_ok, 1);
    idle(10);
    check("hold_fv", frame_valid, 1);
    check("hold_cmd", cmd, 8'h45);
    check("hold_payload", payload, 128'h000102030405060708090A0B0C0D0E0F);
    consume();
    check("consume_fv", frame_valid, 0);

    // Mismatch "C", 16xAA, "D"
    send_frame(8'h43, 8'h44, 8'hAA, 8'h00);
    check("mm_pulse", err_mismatch, 1);
    check("mm_bad", frames_bad, 1);
    check("mm_fv", frame_valid, 0);
    idle(1);
    check("mm_pulse_end", err_mismatch, 0);
    check("mm_count", n_mm, 1);
    send_frame(8'h41, 8'h41, 8'h10, 8'h03);
    check("a_fv", frame_valid, 1);
    check("a_cmd", cmd, 8'h41);
    check("a_payload", payload, exp_pay(8'h10, 8'h03));
    check("a_ok", frames_ok, 2);
    consume();

    // Timeout: "K" + 5 bytes, then 100 idle cycles
    send(8'h4B);
    send_payload(8'h20, 8'h01, 0, 5);
    idle(99);
    check("to_not_yet", err_timeout, 0);
    idle(1);
    check("to_pulse", err_timeout, 1);
    check("to_bad", frames_bad, 2);
    idle(1);
    check("to_pulse_end", err_timeout, 0);
    check("to_count", n_to, 1);
    send_frame(8'h40, 8'h40, 8'h80, 8'h01);
    check("at_fv", frame_valid, 1);
    check("at_cmd", cmd, 8'h40);
    check("at_ok", frames_ok, 3);
    consume();

    // Byte arriving exactly on the expiry cycle keeps the frame alive
    send(8'h4B);
    send_payload(8'h30, 8'h02, 0, 5);
    idle(99);
    send_payload(8'h30, 8'h02, 5, 11);
    send(8'h4B);
    check("exp_no_to", n_to, 1);
    check("exp_fv", frame_valid, 1);
    check("exp_cmd", cmd, 8'h4B);
    check("exp_payload", payload, exp_pay(8'h30, 8'h02));
    check("exp_bad", frames_bad, 2);
    consume();

    // Overrun: "a" held, "b" arrives
    send_frame(8'h61, 8'h61, 8'h01, 8'h01);
    check("ov_a_ok", frames_ok, 5);
    send_frame(8'h62, 8'h62, 8'h50, 8'h01);
    check("ov_pulse", err_overrun, 1);
    check("ov_cmd", cmd, 8'h61);
    check("ov_payload", payload, exp_pay(8'h01, 8'h01));
    check("ov_bad", frames_bad, 3);
    check("ov_ok", frames_ok, 5);
    // Same, but consumed in the trailer cycle
    send(8'h62);
    send_payload(8'h50, 8'h01, 0, 16);
    frame_ready = 1'b1;
    send(8'h62);
    frame_ready = 1'b0;
    check("sim_fv", frame_valid, 1);
    check("sim_cmd", cmd, 8'h62);
    check("sim_payload", payload, exp_pay(8'h50, 8'h01));
    check("sim_no_ov", n_ov, 1);
    check("sim_ok", frames_ok, 6);
    check("sim_bad", frames_bad, 3);
    consume();

    // Reset after 9 bytes of a frame
    send(8'h5A);
    send_payload(8'h77, 8'h01, 0, 8);
    #3 rst = 1'b0;
    #2;
    check("mid_rst_out", {cmd, frame_valid, frames_ok, frames_bad}, 0);
    check("mid_rst_payload", payload, 0);
    idle(2);
    rst = 1'b1;
    idle(3);
    check("post_rst_errs", n_mm + n_to + n_ov, 3);
    send_frame(8'h5A, 8'h5A, 8'h90, 8'h01);
    check("post_rst_fv", frame_valid, 1);
    check("post_rst_cmd", cmd, 8'h5A);
    check("post_rst_payload", payload, exp_pay(8'h90, 8'h01));
    check("post_rst_ok", frames_ok, 1);
    check("post_rst_bad", frames_bad, 0);
    consume();

    // Saturation of frames_bad
    for (int k = 0; k < 300; k++) send_frame(8'h11, 8'h22, 8'h00, 8'h01);
    idle(1);
    check("sat_bad", frames_bad, 8'hFF);
    check("sat_fv", frame_valid, 0);
    check("sat_ok", frames_ok, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_framer.md
# uart_cmd_framer

Byte-stream command framer that sits directly downstream of the UART receiver and directly upstream of the AES command/control logic. It assembles received bytes into fixed-size command frames of the form header, payload, trailer. A frame is valid when the trailer byte equals the header byte. Valid frames are presented as a command byte plus a 128-bit payload on a valid/ready handshake. Malformed, stalled and overrun frames are dropped, and each drop raises an error pulse and increments a counter.

## Interface
- PAYLOAD_BYTES, 16: payload length in bytes; frame length is PAYLOAD_BYTES+2 (18 by default).
- TIMEOUT_CYCLES, 1_000_000: maximum idle gap between bytes inside a frame, in clk cycles (about 9.7 ms at 103.34 MHz).
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte from the UART receiver.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in that cycle.
- cmd  output  8  header byte of the accepted frame.
- payload  output  8*PAYLOAD_BYTES  accepted payload; the first payload byte received is in the MSBs.
- frame_valid  output  1  cmd/payload hold a frame that has not been consumed.
- frame_ready  input  1  consumer accepts the frame in any cycle where frame_valid=1.
- err_mismatch  output  1  one-cycle pulse: trailer differed from header.
- err_timeout  output  1  one-cycle pulse: inter-byte gap exceeded the limit.
- err_overrun  output  1  one-cycle pulse: a good frame was dropped because the output was still held.
- frames_ok  output  8  count of accepted frames; saturates at 255.
- frames_bad  output  8  count of mismatch, timeout and overrun drops; saturates at 255.

## Operation
- States: IDLE (byte_cnt=0) and RECV (byte_cnt 1..PAYLOAD_BYTES+1).
- IDLE:
  - On rx_valid, latch rx_data as the header, set byte_cnt=1 and enter RECV.
  - Every byte value is a legal header.
- RECV, on each rx_valid:
  - While byte_cnt < PAYLOAD_BYTES+1, shift the byte into the payload shift register MSB-first, then increment byte_cnt.
  - When byte_cnt = PAYLOAD_BYTES+1, the byte is the trailer. Evaluate the frame and return to IDLE in the same cycle.
- Frame evaluation:
  - trailer ≠ header: pulse err_mismatch, increment frames_bad, discard the frame.
  - trailer = header, and the output is free or being consumed (frame_valid=0, or frame_ready=1 this cycle): load cmd/payload and set frame_valid. Increment frames_ok.
  - trailer = header, and frame_valid=1 with frame_ready=0: keep the old output. Pulse err_overrun, increment frames_bad.
- The collection shift register is separate from the output register, so a new frame can be received while the previous one is held.
- Timeout:
  - In RECV, a gap counter clears on every rx_valid and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid, pulse err_timeout, increment frames_bad and return to IDLE.
  - The gap counter is held at 0 in IDLE.
- Handshake:
  - frame_valid clears the cycle after frame_valid and frame_ready are both 1, unless a new frame loads in that same cycle.
  - cmd/payload are stable while frame_valid=1.
- Counters saturate at 8'hFF and never wrap.
- Error pulses are mutually exclusive: at most one per frame.

## Timing
- Reset (rst=0, asynchronous): state IDLE; byte_cnt, gap counter and shift register cleared. Outputs: cmd=0, payload=0, frame_valid=0, all err_*=0, frames_ok=0, frames_bad=0.
- Reset asserted mid-frame: the partial frame is lost, and no error pulse is generated on release.
- Latency: frame_valid, err_mismatch and err_overrun rise in the cycle after the trailer's rx_valid cycle.
- err_timeout rises one cycle after the gap counter reaches TIMEOUT_CYCLES-1.
- The counters update in the same cycle as their corresponding pulse.
- rx_valid in the same cycle as timeout expiry: the byte wins, the gap counter clears and no timeout occurs.
- Trailer arriving in the same cycle as frame_ready with frame_valid=1: the new frame loads and there is no overrun.
- Back-to-back rx_valid on consecutive cycles is supported, so a full frame can arrive in 18 cycles.
- Throughput: one frame per PAYLOAD_BYTES+2 rx_valid strobes.

## Test plan
- Good frame:
  - Stimulus: send "E", bytes 8'h00..8'h0F, then "E".
  - Required response: one cycle later frame_valid=1, cmd=8'h45, payload=128'h000102030405060708090A0B0C0D0E0F, frames_ok=1.
  - Holding frame_ready=0 for 10 cycles keeps the outputs stable. One cycle of frame_ready=1 clears frame_valid.
- Mismatch:
  - Stimulus: send "C", 16×8'hAA, then "D".
  - Required response: err_mismatch pulses for exactly 1 cycle, frames_bad=1, frame_valid stays 0.
  - A following good "A"…"A" frame is accepted.
- Timeout:
  - Use TIMEOUT_CYCLES=100. Send "K" plus 5 bytes, then wait 100 cycles.
  - Required response: err_timeout pulses once and the FSM returns to IDLE.
  - A subsequent full "@" frame is accepted with cmd=8'h40.
  - Also drive rx_valid exactly on the expiry cycle: no timeout occurs.
- Overrun and simultaneous consume:
  - Frame 1 ("a") is held with frame_ready=0. Frame 2 ("b") arrives.
  - Required response: err_overrun pulses and cmd stays 8'h61.
  - Repeat with frame_ready=1 in the cycle frame 2's trailer arrives: cmd becomes 8'h62 with no error.
- Reset mid-frame and saturation:
  - Pulse rst low after 9 bytes. Required response: all outputs are 0, then a full frame is accepted normally.
  - Send 300 mismatched frames: frames_bad stays at 255.
